// File: rtl/pc_sequencer.sv
// Program-counter sequencer with priority next-PC selection and a circular
// return-address stack that drops its oldest entry on overflow.
module pc_sequencer #(
  parameter int          WIDTH     = 16,
  parameter int          STEP      = 2,
  parameter int unsigned RESET_PC  = 0,
  parameter int          RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [WIDTH-1:0] branch_off,
  input  logic             jump_en,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_step,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    OP_HOLD, OP_RET, OP_CALL, OP_JUMP, OP_BRANCH, OP_SEQ
  } op_e;

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_empty;
  logic             r_full;
  logic             r_overflow;
  logic             r_underflow;

  op_e              w_op;
  logic [WIDTH-1:0] w_pc_plus_step;
  logic [PTR_W-1:0] w_top_ptr;
  logic             w_is_empty;
  logic             w_is_full;
  logic [WIDTH-1:0] w_next_pc;
  logic [PTR_W-1:0] w_next_ptr;
  logic [CNT_W-1:0] w_next_count;
  logic             w_push;
  logic             w_overflow;
  logic             w_underflow;

  assign w_pc_plus_step = r_pc + WIDTH'(STEP);
  // r_wr_ptr is the next write slot, so the newest entry sits one below it.
  assign w_top_ptr      = r_wr_ptr - PTR_W'(1);
  assign w_is_empty     = (r_count == '0);
  assign w_is_full      = (r_count == CNT_W'(RAS_DEPTH));

  always_comb begin
    if (stall)          w_op = OP_HOLD;
    else if (ret_en)    w_op = OP_RET;
    else if (call_en)   w_op = OP_CALL;
    else if (jump_en)   w_op = OP_JUMP;
    else if (branch_en) w_op = OP_BRANCH;
    else                w_op = OP_SEQ;
  end

  always_comb begin
    // NOTE: every output gets a default before the case, so no path can infer a latch.
    w_next_pc    = r_pc;
    w_next_ptr   = r_wr_ptr;
    w_next_count = r_count;
    w_push       = 1'b0;
    w_overflow   = 1'b0;
    w_underflow  = 1'b0;
    case (w_op)
      OP_HOLD: ;
      OP_RET: begin
        if (w_is_empty) begin
          w_next_pc   = w_pc_plus_step;
          w_underflow = 1'b1;
        end else begin
          w_next_pc    = r_ras[w_top_ptr];
          w_next_ptr   = w_top_ptr;
          w_next_count = r_count - CNT_W'(1);
        end
      end
      OP_CALL: begin
        w_next_pc  = target;
        w_push     = !reset;
        w_next_ptr = r_wr_ptr + PTR_W'(1);
        // When full, the write slot is the oldest entry, so it is simply overwritten.
        if (w_is_full) w_overflow   = 1'b1;
        else           w_next_count = r_count + CNT_W'(1);
      end
      OP_JUMP:   w_next_pc = target;
      OP_BRANCH: w_next_pc = r_pc + branch_off;
      default:   w_next_pc = w_pc_plus_step;
    endcase
  end

  // NOTE: the stack array has no reset; the count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_ras[r_wr_ptr] <= w_pc_plus_step;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= WIDTH'(RESET_PC);
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_pc        <= w_next_pc;
      r_wr_ptr    <= w_next_ptr;
      r_count     <= w_next_count;
      r_empty     <= (w_next_count == '0);
      r_full      <= (w_next_count == CNT_W'(RAS_DEPTH));
      r_overflow  <= w_overflow;
      r_underflow <= w_underflow;
    end
  end

  assign pc            = r_pc;
  assign pc_plus_step  = w_pc_plus_step;
  assign ras_empty     = r_empty;
  assign ras_full      = r_full;
  assign ras_overflow  = r_overflow;
  assign ras_underflow = r_underflow;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, a hand-written
// stall/overflow sequence, then randomized traffic against a queue-based model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, branch_en, jump_en, call_en, ret_en;
  logic [15:0] branch_off, target;
  logic [15:0] pc, pc_plus_step;
  logic        ras_empty, ras_full, ras_overflow, ras_underflow;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.WIDTH(16), .STEP(2), .RESET_PC(0), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_en(branch_en),
    .branch_off(branch_off), .jump_en(jump_en), .call_en(call_en),
    .ret_en(ret_en), .target(target), .pc(pc), .pc_plus_step(pc_plus_step),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst, stall, br, jmp, call, ret;
    logic [15:0] off, tgt;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [15:0] pc;
    logic        empty, full, ovf, udf;
  } vec_t;

  vec_t vecs[$];

  // Reference model: a PC value and a bounded LIFO held in a queue.
  logic [15:0] m_pc;
  logic [15:0] m_stack[$];
  logic        m_ovf, m_udf;

  task automatic model_step(input stim_t s);
    m_ovf = 1'b0;
    m_udf = 1'b0;
    if (s.rst) begin
      m_pc = 16'h0000;
      m_stack.delete();
    end else if (s.stall) begin
    end else if (s.ret) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else begin
        m_pc  = m_pc + 16'd2;
        m_udf = 1'b1;
      end
    end else if (s.call) begin
      m_stack.push_back(m_pc + 16'd2);
      if (m_stack.size() > 4) begin
        void'(m_stack.pop_front());
        m_ovf = 1'b1;
      end
      m_pc = s.tgt;
    end else if (s.jmp) m_pc = s.tgt;
    else if (s.br)      m_pc = m_pc + s.off;
    else                m_pc = m_pc + 16'd2;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%04h expected 0x%04h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input stim_t s);
    @(negedge clk);
    reset      = s.rst;
    stall      = s.stall;
    branch_en  = s.br;
    jump_en    = s.jmp;
    call_en    = s.call;
    ret_en     = s.ret;
    branch_off = s.off;
    target     = s.tgt;
    model_step(s);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " pc"},         pc,                    m_pc);
    check({tag, " pc_plus"},    pc_plus_step,          m_pc + 16'd2);
    check({tag, " empty"},      16'(ras_empty),        16'(m_stack.size() == 0));
    check({tag, " full"},       16'(ras_full),         16'(m_stack.size() == 4));
    check({tag, " overflow"},   16'(ras_overflow),     16'(m_ovf));
    check({tag, " underflow"},  16'(ras_underflow),    16'(m_udf));
  endtask

  // Columns: rst stall br jmp call ret off tgt | pc empty full ovf udf
  task automatic add(input logic rst, st, br, jmp, call, ret,
                     input logic [15:0] off, tgt, epc,
                     input logic ee, ef, eo, eu);
    vec_t v;
    v.s     = '{rst: rst, stall: st, br: br, jmp: jmp, call: call, ret: ret, off: off, tgt: tgt};
    v.pc    = epc;
    v.empty = ee;
    v.full  = ef;
    v.ovf   = eo;
    v.udf   = eu;
    vecs.push_back(v);
  endtask

  function automatic stim_t mk(input logic rst, st, br, jmp, call, ret,
                               input logic [15:0] off, tgt);
    stim_t s;
    s = '{rst: rst, stall: st, br: br, jmp: jmp, call: call, ret: ret, off: off, tgt: tgt};
    return s;
  endfunction

  initial begin
    reset = 1'b1; stall = 1'b0; branch_en = 1'b0; jump_en = 1'b0;
    call_en = 1'b0; ret_en = 1'b0; branch_off = '0; target = '0;

    // Sequential and stall
    add(1,0,0,0,0,0, 16'h0000,16'h0000, 16'h0000, 1,0,0,0);
    add(0,0,0,0,0,0, 16'h0000,16'h0000, 16'h0002, 1,0,0,0);
    add(0,0,0,0,0,0, 16'h0000,16'h0000, 16'h0004, 1,0,0,0);
    add(0,0,0,0,0,0, 16'h0000,16'h0000, 16'h0006, 1,0,0,0);
    add(0,1,0,0,0,0, 16'h0000,16'h0000, 16'h0006, 1,0,0,0);
    add(0,0,0,0,0,0, 16'h0000,16'h0000, 16'h0008, 1,0,0,0);
    // Negative branch and wrap-around
    add(0,0,0,1,0,0, 16'h0000,16'h0010, 16'h0010, 1,0,0,0);
    add(0,0,1,0,0,0, 16'hFFFC,16'h0000, 16'h000C, 1,0,0,0);
    add(0,0,0,1,0,0, 16'h0000,16'hFFFE, 16'hFFFE, 1,0,0,0);
    add(0,0,0,0,0,0, 16'h0000,16'h0000, 16'h0000, 1,0,0,0);
    // Call / return
    add(0,0,0,1,0,0, 16'h0000,16'h0020, 16'h0020, 1,0,0,0);
    add(0,0,0,0,1,0, 16'h0000,16'h0100, 16'h0100, 0,0,0,0);
    add(0,0,0,0,0,1, 16'h0000,16'h0000, 16'h0022, 1,0,0,0);
    // Five nested calls, overflow on the fifth, then LIFO drain and underflow
    add(0,0,0,0,1,0, 16'h0000,16'h1000, 16'h1000, 0,0,0,0);
    add(0,0,0,0,1,0, 16'h0000,16'h2000, 16'h2000, 0,0,0,0);
    add(0,0,0,0,1,0, 16'h0000,16'h3000, 16'h3000, 0,0,0,0);
    add(0,0,0,0,1,0, 16'h0000,16'h4000, 16'h4000, 0,1,0,0);
    add(0,0,0,0,1,0, 16'h0000,16'h5000, 16'h5000, 0,1,1,0);
    add(0,0,0,0,0,1, 16'h0000,16'h0000, 16'h4002, 0,0,0,0);
    add(0,0,0,0,0,1, 16'h0000,16'h0000, 16'h3002, 0,0,0,0);
    add(0,0,0,0,0,1, 16'h0000,16'h0000, 16'h2002, 0,0,0,0);
    add(0,0,0,0,0,1, 16'h0000,16'h0000, 16'h1002, 1,0,0,0);
    add(0,0,0,0,0,1, 16'h0000,16'h0000, 16'h1004, 1,0,0,1);
    // Priority
    add(0,1,1,1,0,1, 16'h0010,16'hAAAA, 16'h1004, 1,0,0,0);
    add(0,0,1,1,0,0, 16'h0040,16'h0300, 16'h0300, 1,0,0,0);
    add(0,0,0,0,1,0, 16'h0000,16'h0400, 16'h0400, 0,0,0,0);
    add(0,0,0,0,1,1, 16'h0000,16'h0500, 16'h0302, 1,0,0,0);
    add(0,0,0,0,0,1, 16'h0000,16'h0000, 16'h0304, 1,0,0,1);
    // Reset in the middle of a populated stack
    add(0,0,0,0,1,0, 16'h0000,16'h0600, 16'h0600, 0,0,0,0);
    add(0,0,0,0,1,0, 16'h0000,16'h0700, 16'h0700, 0,0,0,0);
    add(0,0,0,0,1,0, 16'h0000,16'h0200, 16'h0200, 0,0,0,0);
    add(1,0,0,0,1,0, 16'h0000,16'h0900, 16'h0000, 1,0,0,0);
    add(0,0,0,0,0,1, 16'h0000,16'h0000, 16'h0002, 1,0,0,1);

    foreach (vecs[i]) begin
      drive(vecs[i].s);
      check($sformatf("vec%0d pc", i),        pc,                 vecs[i].pc);
      check($sformatf("vec%0d pc_plus", i),   pc_plus_step,       vecs[i].pc + 16'd2);
      check($sformatf("vec%0d empty", i),     16'(ras_empty),     16'(vecs[i].empty));
      check($sformatf("vec%0d full", i),      16'(ras_full),      16'(vecs[i].full));
      check($sformatf("vec%0d overflow", i),  16'(ras_overflow),  16'(vecs[i].ovf));
      check($sformatf("vec%0d underflow", i), 16'(ras_underflow), 16'(vecs[i].udf));
    end

    // Stall on a full stack with call pending: no push, no pulse; then the call overflows.
    drive(mk(1,0,0,0,0,0, 16'h0, 16'h0));
    for (int i = 0; i < 4; i++) drive(mk(0,0,0,0,1,0, 16'h0, 16'(16'h0100 * (i + 1))));
    check_model("fill");
    drive(mk(0,1,0,0,1,0, 16'h0, 16'h0800));
    check_model("stall_full");
    drive(mk(0,0,0,0,1,0, 16'h0, 16'h0900));
    check_model("ovf_after_stall");
    drive(mk(0,1,0,0,0,0, 16'h0, 16'h0));
    check_model("stall_clears_pulse");

    // Randomized traffic biased toward stack activity.
    for (int n = 0; n < 3000; n++) begin
      stim_t s;
      s.rst   = ($urandom_range(0, 63) == 0);
      s.stall = ($urandom_range(0, 7) == 0);
      s.ret   = ($urandom_range(0, 3) == 0);
      s.call  = ($urandom_range(0, 3) == 0);
      s.jmp   = ($urandom_range(0, 5) == 0);
      s.br    = ($urandom_range(0, 4) == 0);
      s.off   = 16'($urandom);
      s.tgt   = 16'($urandom);
      drive(s);
      check_model($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the PC and address width in bits.
REQ-002 SHALL have parameter STEP, default 2, giving the sequential increment added each advancing cycle.
REQ-003 SHALL have parameter RESET_PC, default 0, giving the PC value loaded on reset.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, giving the return-address stack entry count (power of two, at least 2).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port stall  input  1  hold all state this cycle.
REQ-008 SHALL have port branch_en  input  1  PC-relative branch request.
REQ-009 SHALL have port branch_off  input  WIDTH  two's-complement branch offset.
REQ-010 SHALL have port jump_en  input  1  absolute jump request.
REQ-011 SHALL have port call_en  input  1  call: push return address and jump.
REQ-012 SHALL have port ret_en  input  1  return: pop return address.
REQ-013 SHALL have port target  input  WIDTH  absolute address for jump/call.
REQ-014 SHALL have port pc  output  WIDTH  current PC, registered.
REQ-015 SHALL have port pc_plus_step  output  WIDTH  pc + STEP, combinational.
REQ-016 SHALL have port ras_empty  output  1  stack holds zero entries, registered.
REQ-017 SHALL have port ras_full  output  1  stack holds RAS_DEPTH entries, registered.
REQ-018 SHALL have port ras_overflow  output  1  one-cycle pulse: a push discarded the oldest entry.
REQ-019 SHALL have port ras_underflow  output  1  one-cycle pulse: a pop found the stack empty.

Function
REQ-020 All arithmetic SHALL be modulo 2^WIDTH, and wrap-around SHALL NOT be flagged.
REQ-021 Next-PC priority SHALL be: stall > ret_en > call_en > jump_en > branch_en > sequential.
REQ-022 When stall is high, pc, stack contents, count and flags SHALL hold, and both pulse outputs SHALL be 0.
REQ-023 On ret_en with a non-empty stack, pc SHALL load the top entry and the count SHALL decrement.
REQ-024 On ret_en with an empty stack, pc SHALL load pc+STEP and ras_underflow SHALL pulse high for one cycle.
REQ-025 On call_en, pc+STEP SHALL be pushed and pc SHALL load target.
REQ-026 A call_en on a full stack SHALL overwrite the oldest entry (circular buffer), leave the count at RAS_DEPTH, and pulse ras_overflow.
REQ-027 On jump_en, pc SHALL load target, with the stack unchanged.
REQ-028 On branch_en, pc SHALL load pc + branch_off, with the offset sign-interpreted.
REQ-029 With no request asserted, pc SHALL load pc+STEP.
REQ-030 When ret_en and call_en are asserted together, the return SHALL execute and the call SHALL be discarded, with no push.
REQ-031 Every control input SHALL be sampled at the rising edge, and its effect SHALL be visible on pc after that same edge (latency 1).
REQ-032 ras_empty and ras_full SHALL reflect the post-edge stack count.

Reset
REQ-033 On reset high at a rising edge, regardless of any other input: pc=RESET_PC, count=0, ras_empty=1, ras_full=0, ras_overflow=0, ras_underflow=0.
REQ-034 Reset asserted mid-operation SHALL discard all stack entries, and stack contents need not be cleared.

Verification (WIDTH=16, STEP=2, RESET_PC=0, RAS_DEPTH=4)
REQ-035 Sequential and stall: reset, then 3 idle cycles -> pc 0x0000, 0x0002, 0x0004, 0x0006; then stall=1 for one cycle -> pc stays 0x0006; then idle -> pc 0x0008.
REQ-036 Branch and wrap: at pc=0x0010, branch_off=0xFFFC -> pc=0x000C; at pc=0xFFFE idle -> pc=0x0000 with no flag.
REQ-037 Call/return: at pc=0x0020, call_en with target=0x0100 -> pc=0x0100 and ras_empty=0; next cycle ret_en -> pc=0x0022 and ras_empty=1.
REQ-038 Overflow then LIFO drain: 5 nested calls -> ras_overflow pulses on the 5th only and ras_full=1; 4 returns -> addresses come back in reverse order, calls 5 to 2; 5th return -> pc=pc+2 with ras_underflow pulse.
REQ-039 Priority: stall=1 with jump_en, branch_en and ret_en all high -> nothing changes; then jump_en with branch_en -> pc=target; then call_en with ret_en on a 1-entry stack -> pc=popped address, no push.
REQ-040 Reset mid-operation: with 3 stack entries and pc=0x0200, reset=1 for one cycle with call_en=1 -> pc=0x0000, ras_empty=1, no pulses; a following ret_en -> ras_underflow pulse.
